espacc_dma_burst_engine: RTL and testbench

//  Parametrised DMA front-end for ESP RTL accelerators; successor to the fixed 64-bit single-burst logic in espacc_rtl_basic_dma.

---
 rtl/espacc_dma_pkg.sv | 23 ++
 rtl/espacc_dma_unpack.sv | 48 ++++
 rtl/espacc_dma_burst_engine.sv | 214 +++++++++++++++++++++
 tb/tb_espacc_dma_burst_engine.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/espacc_dma_pkg.sv
// Shared types and constants for the ESP DMA burst engine.
//   dma_state_t : engine FSM states (encoding is visible on the debug port)
//   SIZE_*      : ESP dma ctrl data_size codes
//   min_u32     : unsigned minimum used for burst length clamping
package espacc_dma_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_CTRL = 3'd1,
        RD_DATA = 3'd2,
        WR_CTRL = 3'd3,
        WR_DATA = 3'd4,
        DONE    = 3'd5
    } dma_state_t;

    localparam logic [2:0] SIZE_WORD  = 3'b010;
    localparam logic [2:0] SIZE_DWORD = 3'b011;

    function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/espacc_dma_unpack.sv
// Beat-to-word unpacker for the DMA read path.
// Holds one bus beat and presents its valid words low word first.
//   clk, rst       : clock, async active-low reset
//   load/load_data : capture a beat (only while empty)
//   load_cnt       : number of words of the beat that are real (tail beat may be short)
//   pop            : current word accepted by the consumer
//   word_valid/word_data : current word
//   empty          : no words left; a new beat may be loaded
module espacc_dma_unpack
    import espacc_dma_pkg::*;
#(
    parameter int BUS_W  = 64,
    parameter int WORD_W = 32,
    parameter int CW     = $clog2(BUS_W / WORD_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [BUS_W-1:0]  load_data,
    input  logic [CW-1:0]     load_cnt,
    input  logic              pop,
    output logic              word_valid,
    output logic [WORD_W-1:0] word_data,
    output logic              empty
);

    logic [BUS_W-1:0] beat;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat <= '0;
            cnt  <= '0;
        end else if (load) begin
            beat <= load_data;
            cnt  <= load_cnt;
        end else if (pop && cnt != '0) begin
            // Shift the next word down so the output is always the low slice.
            beat <= beat >> WORD_W;
            cnt  <= cnt - CW'(1);
        end
    end

    assign word_data  = beat[WORD_W-1:0];
    assign word_valid = (cnt != '0);
    assign empty      = (cnt == '0);

endmodule

// File: rtl/espacc_dma_burst_engine.sv
// DMA front-end for ESP RTL accelerators.
// Splits word-granular core requests into ESP dma_read/dma_write bursts of at
// most MAX_BURST beats, unpacking read beats into words and packing write words
// into beats.
//   clk, rst                 : clock, async active-low reset
//   req_*                    : core request (write flag, host word index, word count)
//   rd_word_*                : read words to the core
//   wr_word_*                : write words from the core
//   done                     : one-cycle completion pulse
//   dma_read_ctrl_* / chnl_* : ESP read handshakes
//   dma_write_ctrl_* / chnl_*: ESP write handshakes
//   debug                    : {24'b0, burst_cnt[4:0], state}
module espacc_dma_burst_engine
    import espacc_dma_pkg::*;
#(
    parameter int DMA_BUS_WIDTH = 64,
    parameter int WORD_WIDTH    = 32,
    parameter int MAX_BURST     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [31:0]              req_index,
    input  logic [31:0]              req_words,
    output logic                     rd_word_valid,
    input  logic                     rd_word_ready,
    output logic [31:0]              rd_word_data,
    input  logic                     wr_word_valid,
    output logic                     wr_word_ready,
    input  logic [31:0]              wr_word_data,
    output logic                     done,
    output logic                     dma_read_ctrl_valid,
    input  logic                     dma_read_ctrl_ready,
    output logic [31:0]              dma_read_ctrl_data_index,
    output logic [31:0]              dma_read_ctrl_data_length,
    output logic [2:0]               dma_read_ctrl_data_size,
    input  logic                     dma_read_chnl_valid,
    input  logic [DMA_BUS_WIDTH-1:0] dma_read_chnl_data,
    output logic                     dma_read_chnl_ready,
    output logic                     dma_write_ctrl_valid,
    input  logic                     dma_write_ctrl_ready,
    output logic [31:0]              dma_write_ctrl_data_index,
    output logic [31:0]              dma_write_ctrl_data_length,
    output logic [2:0]               dma_write_ctrl_data_size,
    output logic                     dma_write_chnl_valid,
    input  logic                     dma_write_chnl_ready,
    output logic [DMA_BUS_WIDTH-1:0] dma_write_chnl_data,
    output logic [31:0]              debug
);

    localparam int         WPB      = DMA_BUS_WIDTH / WORD_WIDTH;
    localparam int         WPB_LOG2 = $clog2(WPB);
    localparam int         CW       = $clog2(WPB + 1);
    localparam logic [2:0] BUS_SIZE = (DMA_BUS_WIDTH == 64) ? SIZE_DWORD : SIZE_WORD;

    dma_state_t state, next_state;

    logic [31:0] words_left;   // words not yet handed to / taken from the core
    logic [31:0] beats_left;   // beats not yet transferred on the chnl
    logic [31:0] burst_cnt;    // beats transferred in the current burst
    logic [31:0] ctrl_index;
    logic [31:0] ctrl_length;
    logic [2:0]  data_size;

    logic [DMA_BUS_WIDTH-1:0] pack_data;
    logic [CW-1:0]            pack_cnt;
    logic                     wbeat_valid;

    logic        burst_done, req_fire, rd_beat_fire, rd_pop, wr_fire, wr_beat_fire;
    logic        up_empty, next_burst;
    logic [32:0] beats_sum;
    logic [31:0] total_beats;
    logic [CW-1:0] up_load_cnt;

    // 33-bit sum so a word count near 2^32 cannot wrap the beat count.
    assign beats_sum   = {1'b0, req_words} + 33'(WPB - 1);
    assign total_beats = 32'(beats_sum >> WPB_LOG2);

    assign burst_done   = (burst_cnt == ctrl_length);
    assign req_fire     = req_valid && req_ready;
    assign rd_beat_fire = dma_read_chnl_valid && dma_read_chnl_ready;
    assign rd_pop       = rd_word_valid && rd_word_ready;
    assign wr_fire      = wr_word_valid && wr_word_ready;
    assign wr_beat_fire = wbeat_valid && dma_write_chnl_ready;
    assign next_burst   = (state == RD_DATA && next_state == RD_CTRL) ||
                          (state == WR_DATA && next_state == WR_CTRL);

    // Tail beat: only the words still owed to the core are presented.
    assign up_load_cnt = (words_left < 32'(WPB)) ? words_left[CW-1:0] : CW'(WPB);

    espacc_dma_unpack #(
        .BUS_W  (DMA_BUS_WIDTH),
        .WORD_W (WORD_WIDTH),
        .CW     (CW)
    ) u_unpack (
        .clk        (clk),
        .rst        (rst),
        .load       (rd_beat_fire),
        .load_data  (dma_read_chnl_data),
        .load_cnt   (up_load_cnt),
        .pop        (rd_pop),
        .word_valid (rd_word_valid),
        .word_data  (rd_word_data),
        .empty      (up_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state           = state;
        req_ready            = 1'b0;
        done                 = 1'b0;
        dma_read_ctrl_valid  = 1'b0;
        dma_write_ctrl_valid = 1'b0;
        dma_read_chnl_ready  = 1'b0;
        wr_word_ready        = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    next_state = (req_words == '0) ? DONE : (req_write ? WR_CTRL : RD_CTRL);
            end
            RD_CTRL: begin
                dma_read_ctrl_valid = 1'b1;
                if (dma_read_ctrl_ready) next_state = RD_DATA;
            end
            RD_DATA: begin
                // Take a new beat only once the previous one is fully drained.
                dma_read_chnl_ready = up_empty && !burst_done;
                if (burst_done && up_empty)
                    next_state = (beats_left == '0) ? DONE : RD_CTRL;
            end
            WR_CTRL: begin
                dma_write_ctrl_valid = 1'b1;
                if (dma_write_ctrl_ready) next_state = WR_DATA;
            end
            WR_DATA: begin
                wr_word_ready = !wbeat_valid && (words_left != '0) && !burst_done;
                if (burst_done && !wbeat_valid)
                    next_state = (beats_left == '0) ? DONE : WR_CTRL;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            words_left  <= '0;
            beats_left  <= '0;
            burst_cnt   <= '0;
            ctrl_index  <= '0;
            ctrl_length <= '0;
            data_size   <= SIZE_WORD;
            pack_data   <= '0;
            pack_cnt    <= '0;
            wbeat_valid <= 1'b0;
        end else begin
            if (req_fire) begin
                words_left  <= req_words;
                beats_left  <= total_beats;
                burst_cnt   <= '0;
                ctrl_index  <= req_index >> WPB_LOG2;
                ctrl_length <= min_u32(total_beats, 32'(MAX_BURST));
                data_size   <= BUS_SIZE;
            end else begin
                if (rd_pop || wr_fire)
                    words_left <= words_left - 32'd1;
                if (rd_beat_fire || wr_beat_fire) begin
                    beats_left <= beats_left - 32'd1;
                    burst_cnt  <= burst_cnt + 32'd1;
                end
                if (next_burst) begin
                    burst_cnt   <= '0;
                    ctrl_index  <= ctrl_index + ctrl_length;
                    ctrl_length <= min_u32(beats_left, 32'(MAX_BURST));
                end
            end

            // Pack register is zeroed after each beat so a short tail beat
            // carries zeros in its unused upper words.
            if (wr_beat_fire) begin
                pack_data   <= '0;
                pack_cnt    <= '0;
                wbeat_valid <= 1'b0;
            end else if (wr_fire) begin
                pack_data[int'(pack_cnt)*WORD_WIDTH +: WORD_WIDTH] <= wr_word_data;
                if (32'(pack_cnt) + 32'd1 == 32'(WPB) || words_left == 32'd1)
                    wbeat_valid <= 1'b1;
                else
                    pack_cnt <= pack_cnt + CW'(1);
            end
        end
    end

    assign dma_read_ctrl_data_index   = ctrl_index;
    assign dma_read_ctrl_data_length  = ctrl_length;
    assign dma_read_ctrl_data_size    = data_size;
    assign dma_write_ctrl_data_index  = ctrl_index;
    assign dma_write_ctrl_data_length = ctrl_length;
    assign dma_write_ctrl_data_size   = data_size;
    assign dma_write_chnl_valid       = wbeat_valid;
    assign dma_write_chnl_data        = pack_data;
    assign debug                      = {24'b0, burst_cnt[4:0], state};

endmodule

// File: tb/tb_espacc_dma_burst_engine.sv
module tb_espacc_dma_burst_engine;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // shared stimulus / host inputs
    logic        req_valid = 0, req_write = 0, rd_word_ready = 1, wr_word_valid = 0;
    logic [31:0] req_index = 0, req_words = 0, wr_word_data = 0;
    logic        rctrl_ready = 1, rchnl_valid = 0, wctrl_ready = 1, wchnl_ready = 1;
    logic [63:0] rchnl_data = 0;
    logic        sel32 = 0, rd_toggle = 0;

    // 64-bit bus DUT outputs
    logic        a_req_ready, a_rd_valid, a_wr_ready, a_done, a_rcv, a_rchr, a_wcv, a_wchv;
    logic [31:0] a_rd_data, a_rci, a_rcl, a_wci, a_wcl, a_dbg;
    logic [2:0]  a_rcs, a_wcs;
    logic [63:0] a_wchd;
    // 32-bit bus DUT outputs
    logic        b_req_ready, b_rd_valid, b_wr_ready, b_done, b_rcv, b_rchr, b_wcv, b_wchv;
    logic [31:0] b_rd_data, b_rci, b_rcl, b_wci, b_wcl, b_dbg, b_wchd;
    logic [2:0]  b_rcs, b_wcs;

    espacc_dma_burst_engine #(.DMA_BUS_WIDTH(64), .WORD_WIDTH(32), .MAX_BURST(8)) u64 (
        .clk(clk), .rst(rst), .req_valid(req_valid && !sel32), .req_ready(a_req_ready),
        .req_write(req_write), .req_index(req_index), .req_words(req_words),
        .rd_word_valid(a_rd_valid), .rd_word_ready(rd_word_ready), .rd_word_data(a_rd_data),
        .wr_word_valid(wr_word_valid), .wr_word_ready(a_wr_ready), .wr_word_data(wr_word_data),
        .done(a_done),
        .dma_read_ctrl_valid(a_rcv), .dma_read_ctrl_ready(rctrl_ready),
        .dma_read_ctrl_data_index(a_rci), .dma_read_ctrl_data_length(a_rcl), .dma_read_ctrl_data_size(a_rcs),
        .dma_read_chnl_valid(rchnl_valid), .dma_read_chnl_data(rchnl_data), .dma_read_chnl_ready(a_rchr),
        .dma_write_ctrl_valid(a_wcv), .dma_write_ctrl_ready(wctrl_ready),
        .dma_write_ctrl_data_index(a_wci), .dma_write_ctrl_data_length(a_wcl), .dma_write_ctrl_data_size(a_wcs),
        .dma_write_chnl_valid(a_wchv), .dma_write_chnl_ready(wchnl_ready), .dma_write_chnl_data(a_wchd),
        .debug(a_dbg));

    espacc_dma_burst_engine #(.DMA_BUS_WIDTH(32), .WORD_WIDTH(32), .MAX_BURST(8)) u32 (
        .clk(clk), .rst(rst), .req_valid(req_valid && sel32), .req_ready(b_req_ready),
        .req_write(req_write), .req_index(req_index), .req_words(req_words),
        .rd_word_valid(b_rd_valid), .rd_word_ready(rd_word_ready), .rd_word_data(b_rd_data),
        .wr_word_valid(wr_word_valid), .wr_word_ready(b_wr_ready), .wr_word_data(wr_word_data),
        .done(b_done),
        .dma_read_ctrl_valid(b_rcv), .dma_read_ctrl_ready(rctrl_ready),
        .dma_read_ctrl_data_index(b_rci), .dma_read_ctrl_data_length(b_rcl), .dma_read_ctrl_data_size(b_rcs),
        .dma_read_chnl_valid(rchnl_valid), .dma_read_chnl_data(rchnl_data[31:0]), .dma_read_chnl_ready(b_rchr),
        .dma_write_ctrl_valid(b_wcv), .dma_write_ctrl_ready(wctrl_ready),
        .dma_write_ctrl_data_index(b_wci), .dma_write_ctrl_data_length(b_wcl), .dma_write_ctrl_data_size(b_wcs),
        .dma_write_chnl_valid(b_wchv), .dma_write_chnl_ready(wchnl_ready), .dma_write_chnl_data(b_wchd),
        .debug(b_dbg));

    // view of whichever DUT is under test
    logic        c_req_ready, c_rd_valid, c_wr_ready, c_done, c_rcv, c_rchr, c_wcv, c_wchv;
    logic [31:0] c_rd_data, c_rci, c_rcl, c_wci, c_wcl, c_dbg;
    logic [2:0]  c_rcs, c_wcs;
    logic [63:0] c_wchd;
    assign c_req_ready = sel32 ? b_req_ready : a_req_ready;
    assign c_rd_valid  = sel32 ? b_rd_valid  : a_rd_valid;
    assign c_rd_data   = sel32 ? b_rd_data   : a_rd_data;
    assign c_wr_ready  = sel32 ? b_wr_ready  : a_wr_ready;
    assign c_done      = sel32 ? b_done      : a_done;
    assign c_rcv       = sel32 ? b_rcv       : a_rcv;
    assign c_rci       = sel32 ? b_rci       : a_rci;
    assign c_rcl       = sel32 ? b_rcl       : a_rcl;
    assign c_rcs       = sel32 ? b_rcs       : a_rcs;
    assign c_rchr      = sel32 ? b_rchr      : a_rchr;
    assign c_wcv       = sel32 ? b_wcv       : a_wcv;
    assign c_wci       = sel32 ? b_wci       : a_wci;
    assign c_wcl       = sel32 ? b_wcl       : a_wcl;
    assign c_wcs       = sel32 ? b_wcs       : a_wcs;
    assign c_wchv      = sel32 ? b_wchv      : a_wchv;
    assign c_wchd      = sel32 ? {32'h0, b_wchd} : a_wchd;
    assign c_dbg       = sel32 ? b_dbg       : a_dbg;

    int checks = 0, errors = 0;
    logic [67:0] exp_ctrl[$];
    logic [31:0] exp_word[$];
    logic [63:0] exp_beat[$];
    int          exp_done = 0;
    int          rbeats = 0;
    logic [31:0] host_q[$];

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic unexpected(input string nm, input logic [127:0] got);
        checks++;
        errors++;
        $display("FAIL %s got %0h want no event", nm, got);
    endtask

    function automatic logic [67:0] mkc(input logic w, input logic [31:0] i, input logic [31:0] l,
                                        input logic [2:0] s);
        return {w, i, l, s};
    endfunction

    // host memory: word at address a holds a+1
    function automatic logic [63:0] beat_data(input logic [31:0] b);
        if (sel32) return {32'h0, b + 32'd1};
        return {b * 32'd2 + 32'd2, b * 32'd2 + 32'd1};
    endfunction

    // ESP host model: answers ctrl requests, streams read beats, accepts write beats
    initial begin
        int cyc;
        logic rc_fire, rch_fire;
        logic [31:0] ci, cl;
        cyc = 0;
        forever begin
            @(negedge clk);
            rc_fire  = rst && c_rcv && rctrl_ready;
            rch_fire = rst && rchnl_valid && c_rchr;
            ci = c_rci;
            cl = c_rcl;
            if (rch_fire) rbeats++;
            @(posedge clk);
            #1;
            cyc++;
            if (!rst) host_q.delete();
            else begin
                if (rch_fire) void'(host_q.pop_front());
                if (rc_fire) for (int i = 0; i < int'(cl); i++) host_q.push_back(ci + 32'(i));
            end
            rchnl_valid   = (host_q.size() != 0) && (cyc % 4 != 3);
            rchnl_data    = (host_q.size() != 0) ? beat_data(host_q[0]) : 64'h0;
            rctrl_ready   = (cyc % 5 != 0);
            wctrl_ready   = (cyc % 5 != 2);
            wchnl_ready   = (cyc % 3 != 2);
            rd_word_ready = rd_toggle ? !rd_word_ready : 1'b1;
        end
    end

    // scoreboard monitor
    logic done_prev = 0;
    int   done_cnt = 0;
    always @(negedge clk) begin
        if (!rst) done_prev = 1'b0;
        else begin
            if (c_rcv && rctrl_ready) begin
                if (exp_ctrl.size() == 0) unexpected("rd_ctrl", mkc(0, c_rci, c_rcl, c_rcs));
                else chk("rd_ctrl", mkc(0, c_rci, c_rcl, c_rcs), exp_ctrl.pop_front());
            end
            if (c_wcv && wctrl_ready) begin
                if (exp_ctrl.size() == 0) unexpected("wr_ctrl", mkc(1, c_wci, c_wcl, c_wcs));
                else chk("wr_ctrl", mkc(1, c_wci, c_wcl, c_wcs), exp_ctrl.pop_front());
            end
            if (c_rd_valid) chk("rchnl_ready_while_word", c_rchr, 0);
            if (c_rd_valid && rd_word_ready) begin
                if (exp_word.size() == 0) unexpected("rd_word", c_rd_data);
                else chk("rd_word", c_rd_data, exp_word.pop_front());
            end
            if (c_wchv && wchnl_ready) begin
                if (exp_beat.size() == 0) unexpected("wr_beat", c_wchd);
                else chk("wr_beat", c_wchd, exp_beat.pop_front());
            end
            if (c_done) begin
                chk("done_single_cycle", done_prev, 0);
                if (exp_done == 0) unexpected("done", 1);
                else begin
                    exp_done--;
                    chk("done_after_data", {32'(exp_ctrl.size()), 32'(exp_word.size()), 32'(exp_beat.size())}, 0);
                end
                done_cnt++;
            end
            done_prev = c_done;
        end
    end

    task automatic check_reset(input string nm);
        chk(nm, {c_dbg, c_req_ready, c_rcv, c_wcv, c_rci, c_rcl, c_rcs, c_wci, c_wcl, c_wcs,
                 c_rd_valid, c_rchr, c_wchv, c_wr_ready, c_done},
                {32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010, 32'h0, 32'h0, 3'b010,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        chk({nm, "_data"}, {c_rd_data, c_wchd}, 0);
    endtask

    task automatic issue(input logic w, input logic [31:0] idx, input logic [31:0] n);
        req_write = w; req_index = idx; req_words = n; req_valid = 1'b1;
        @(negedge clk);
        chk("req_ready_idle", c_req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic send_words(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            bit fired;
            fired = 0;
            wr_word_valid = 1'b1;
            wr_word_data  = base + 32'(i);
            for (int t = 0; t < 300 && !fired; t++) begin
                @(negedge clk);
                fired = c_wr_ready;
                @(posedge clk);
                #1;
            end
            if (!fired) unexpected("wr_word_timeout", i);
        end
        wr_word_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 0;
        for (int t = 0; t < 3000 && !ok; t++) begin
            @(negedge clk);
            ok = (exp_done == 0);
        end
        if (!ok) unexpected("done_timeout", exp_done);
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input logic [31:0] first, input int n);
        for (int i = 0; i < n; i++) exp_word.push_back(first + 32'(i));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        check_reset("reset64");
        sel32 = 1;
        #1;
        check_reset("reset32");
        sel32 = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // 64b read 16 words: single burst of 8
        exp_ctrl.push_back(mkc(0, 0, 8, 3'b011)); push_words(1, 16); exp_done++;
        issue(0, 0, 16); wait_done();

        // 64b read 40 words: bursts 8,8,4
        exp_ctrl.push_back(mkc(0, 0, 8, 3'b011));
        exp_ctrl.push_back(mkc(0, 8, 8, 3'b011));
        exp_ctrl.push_back(mkc(0, 16, 4, 3'b011));
        push_words(1, 40); exp_done++;
        issue(0, 0, 40); wait_done();

        // 64b read 3 words: upper word of the tail beat discarded
        exp_ctrl.push_back(mkc(0, 0, 2, 3'b011)); push_words(1, 3); exp_done++;
        issue(0, 0, 3); wait_done();

        // misaligned index 5 truncates to beat 2 (words 4,5 -> values 5,6)
        exp_ctrl.push_back(mkc(0, 2, 1, 3'b011)); push_words(5, 2); exp_done++;
        issue(0, 5, 2); wait_done();

        // 64b write 5 words A..E
        exp_ctrl.push_back(mkc(1, 0, 3, 3'b011));
        exp_beat.push_back(64'h0000000B_0000000A);
        exp_beat.push_back(64'h0000000D_0000000C);
        exp_beat.push_back(64'h00000000_0000000E);
        exp_done++;
        issue(1, 0, 5); send_words(32'hA, 5); wait_done();

        // 64b write 20 words at index 16: bursts 8,2 starting at beat 8
        exp_ctrl.push_back(mkc(1, 8, 8, 3'b011));
        exp_ctrl.push_back(mkc(1, 16, 2, 3'b011));
        for (int k = 0; k < 10; k++)
            exp_beat.push_back({32'h200 + 32'(2*k + 1), 32'h200 + 32'(2*k)});
        exp_done++;
        issue(1, 16, 20); send_words(32'h200, 20); wait_done();

        // zero-length request
        exp_done++;
        issue(0, 0, 0);
        @(negedge clk);
        chk("zero_done", c_done, 1);
        chk("zero_no_ctrl", {c_rcv, c_wcv}, 0);
        @(negedge clk);
        chk("zero_done_width", c_done, 0);
        chk("zero_req_ready", c_req_ready, 1);
        wait_done();

        // 32b bus read 3 words with rd_word_ready toggling
        sel32 = 1;
        rd_toggle = 1;
        exp_ctrl.push_back(mkc(0, 0, 3, 3'b010)); push_words(1, 3); exp_done++;
        issue(0, 0, 3); wait_done();
        rd_toggle = 0;

        // 32b bus write 2 words at index 4
        exp_ctrl.push_back(mkc(1, 4, 2, 3'b010));
        exp_beat.push_back(64'h55); exp_beat.push_back(64'h56);
        exp_done++;
        issue(1, 4, 2); send_words(32'h55, 2); wait_done();
        sel32 = 0;
        @(posedge clk);
        #1;

        // reset during a read burst, then a fresh read
        begin
            int start;
            bit hit;
            start = rbeats;
            hit = 0;
            exp_ctrl.push_back(mkc(0, 0, 8, 3'b011)); push_words(1, 16);
            issue(0, 0, 16);
            for (int t = 0; t < 500 && !hit; t++) begin
                @(negedge clk);
                hit = (rbeats >= start + 2);
            end
            if (!hit) unexpected("reset_wait_timeout", rbeats);
            @(posedge clk);
            #1;
            rst = 1'b0;
            @(negedge clk);
            check_reset("reset_mid");
            exp_ctrl.delete(); exp_word.delete(); exp_beat.delete();
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b1;
            @(posedge clk);
            #1;
        end
        exp_ctrl.push_back(mkc(0, 0, 2, 3'b011)); push_words(1, 4); exp_done++;
        issue(0, 0, 4); wait_done();

        repeat (3) @(negedge clk);
        chk("queues_empty", {32'(exp_ctrl.size()), 32'(exp_word.size()), 32'(exp_beat.size()), 32'(exp_done)}, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
